sprite_attr_table: RTL and testbench

Receiving end of the sprite attribute load interface. A sequencer drives `load_pos`/`load_att` with `sprite_sel`, `x`, `y` and `visable`; this block stores those attributes for 32 sprites. Once per scanline it scans the table to build a list of the sprites on that line. Per pixel it reports which sprite, if any, covers the pixel, plus the texel row and column offsets that the pixel mixer uses to fetch sprite bitmap data.

---
 rtl/sprite_attr_table.sv | 218 +++++++++++++++++++++
 tb/tb_sprite_attr_table.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_attr_table.sv
// sprite_attr_table
// Stores position and enable attributes for NSPR sprites. Once per scanline
// it scans the table into a short list of the sprites on that line. Per pixel
// it reports which listed sprite covers the pixel, with the texel offsets.
//
// Ports:
//   clk, rst           : rising-edge clock, asynchronous active-low reset
//   load_pos, load_att : write x/y and/or visable into entry sprite_sel
//   sprite_sel, x, y   : entry index and sprite top-left corner
//   visable            : sprite enable
//   line_start, line_y : start a scan for scanline line_y
//   pix_valid, px      : current pixel column, qualified by pix_valid
//   hit, spr_idx       : registered lookup result (covering sprite)
//   row, col           : texel row/column offset inside that sprite
//   scan_busy          : a scan is in progress
//   overflow           : last committed scan found more than NSLOT sprites
module sprite_attr_table #(
  parameter int NSPR  = 32,
  parameter int NSLOT = 4,
  parameter int SSIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_pos,
  input  logic       load_att,
  input  logic [4:0] sprite_sel,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       visable,
  input  logic       line_start,
  input  logic [8:0] line_y,
  input  logic       pix_valid,
  input  logic [9:0] px,
  output logic       hit,
  output logic [4:0] spr_idx,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       scan_busy,
  output logic       overflow
);

  localparam int IW = $clog2(NSPR);
  localparam int SW = $clog2(NSLOT);
  localparam int CW = $clog2(NSLOT + 1);
  localparam logic [IW-1:0] LAST_ENTRY = IW'(NSPR - 1);
  localparam logic [CW-1:0] SLOT_FULL  = CW'(NSLOT);
  localparam logic [9:0]    VSIZE      = 10'(SSIZE);
  localparam logic [10:0]   HSIZE      = 11'(SSIZE);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} scan_state_t;

  scan_state_t state, state_next;

  logic          ent_vis [NSPR];
  logic [9:0]    ent_x   [NSPR];
  logic [8:0]    ent_y   [NSPR];

  logic [8:0]    scan_line;
  logic [IW-1:0] scan_idx;
  logic          scan_clear, scan_step, scan_commit;

  logic [IW-1:0] sh_idx [NSLOT];
  logic [3:0]    sh_row [NSLOT];
  logic [9:0]    sh_x   [NSLOT];
  logic [CW-1:0] sh_cnt;
  logic          sh_ovf;

  logic [IW-1:0] act_idx [NSLOT];
  logic [3:0]    act_row [NSLOT];
  logic [9:0]    act_x   [NSLOT];
  logic [CW-1:0] act_cnt;

  logic [9:0]    dy;
  logic          ent_match;

  logic          lk_hit;
  logic [IW-1:0] lk_idx;
  logic [3:0]    lk_row, lk_col;

  // Attribute table. Writes land on the clock edge, so a scan reading the
  // same entry in the write cycle still sees the old contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < NSPR; e++) begin
        ent_vis[e] <= 1'b0;
        ent_x[e]   <= '0;
        ent_y[e]   <= '0;
      end
    end else begin
      if (load_pos) begin
        ent_x[sprite_sel] <= x;
        ent_y[sprite_sel] <= y;
      end
      if (load_att) begin
        ent_vis[sprite_sel] <= visable;
      end
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: line_start restarts from any state; otherwise walk all
  // entries and spend one cycle committing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (line_start) state_next = SCAN;
      SCAN:    if (line_start) state_next = SCAN;
               else if (scan_idx == LAST_ENTRY) state_next = COMMIT;
      COMMIT:  state_next = line_start ? SCAN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. A restart pre-empts both the current read and the commit.
  always_comb begin
    scan_busy   = (state != IDLE);
    scan_clear  = line_start;
    scan_step   = (state == SCAN) && !line_start;
    scan_commit = (state == COMMIT) && !line_start;
  end

  // Vertical test for the entry under the scan pointer. Done at 10 bits so
  // lines above the sprite give a large difference instead of wrapping.
  always_comb begin
    dy        = {1'b0, scan_line} - {1'b0, ent_y[scan_idx]};
    ent_match = ent_vis[scan_idx] && (scan_line >= ent_y[scan_idx]) && (dy < VSIZE);
  end

  // Shadow list build and commit into the active list. The active list is
  // only replaced at commit, so lookups keep using the previous line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_line <= '0;
      scan_idx  <= '0;
      sh_cnt    <= '0;
      sh_ovf    <= 1'b0;
      act_cnt   <= '0;
      overflow  <= 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
        sh_idx[s]  <= '0;
        sh_row[s]  <= '0;
        sh_x[s]    <= '0;
        act_idx[s] <= '0;
        act_row[s] <= '0;
        act_x[s]   <= '0;
      end
    end else if (scan_clear) begin
      scan_line <= line_y;
      scan_idx  <= '0;
      sh_cnt    <= '0;
      sh_ovf    <= 1'b0;
    end else if (scan_step) begin
      scan_idx <= scan_idx + 1'b1;
      if (ent_match) begin
        if (sh_cnt < SLOT_FULL) begin
          sh_idx[sh_cnt[SW-1:0]] <= scan_idx;
          sh_row[sh_cnt[SW-1:0]] <= dy[3:0];
          sh_x[sh_cnt[SW-1:0]]   <= ent_x[scan_idx];
          sh_cnt                 <= sh_cnt + 1'b1;
        end else begin
          sh_ovf <= 1'b1;
        end
      end
    end else if (scan_commit) begin
      act_cnt  <= sh_cnt;
      overflow <= sh_ovf;
      for (int s = 0; s < NSLOT; s++) begin
        act_idx[s] <= sh_idx[s];
        act_row[s] <= sh_row[s];
        act_x[s]   <= sh_x[s];
      end
    end
  end

  // Pixel lookup over the active list. Walking slots from high to low lets
  // the lowest matching slot (lowest sprite index) win.
  always_comb begin
    logic [10:0] dx_s;
    dx_s   = '0;
    lk_hit = 1'b0;
    lk_idx = '0;
    lk_row = '0;
    lk_col = '0;
    for (int s = NSLOT - 1; s >= 0; s--) begin
      dx_s = {1'b0, px} - {1'b0, act_x[s]};
      if (pix_valid && (CW'(s) < act_cnt) && (px >= act_x[s]) && (dx_s < HSIZE)) begin
        lk_hit = 1'b1;
        lk_idx = act_idx[s];
        lk_row = act_row[s];
        lk_col = dx_s[3:0];
      end
    end
  end

  // Registered lookup result, one cycle after px is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit     <= 1'b0;
      spr_idx <= '0;
      row     <= '0;
      col     <= '0;
    end else begin
      hit     <= lk_hit;
      spr_idx <= lk_idx;
      row     <= lk_row;
      col     <= lk_col;
    end
  end

endmodule

// File: tb/tb_sprite_attr_table.sv
// Self-checking bench for sprite_attr_table. A reference model of the table
// and of the committed sprite list predicts each pixel lookup; predictions are
// queued when px is driven and compared when the registered result appears.
module tb_sprite_attr_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_pos = 1'b0;
  logic       load_att = 1'b0;
  logic [4:0] sprite_sel = '0;
  logic [9:0] x = '0;
  logic [8:0] y = '0;
  logic       visable = 1'b0;
  logic       line_start = 1'b0;
  logic [8:0] line_y = '0;
  logic       pix_valid = 1'b0;
  logic [9:0] px = '0;
  logic       hit;
  logic [4:0] spr_idx;
  logic [3:0] row;
  logic [3:0] col;
  logic       scan_busy;
  logic       overflow;

  sprite_attr_table #(.NSPR(32), .NSLOT(4), .SSIZE(16)) dut (
    .clk(clk), .rst(rst),
    .load_pos(load_pos), .load_att(load_att), .sprite_sel(sprite_sel),
    .x(x), .y(y), .visable(visable),
    .line_start(line_start), .line_y(line_y),
    .pix_valid(pix_valid), .px(px),
    .hit(hit), .spr_idx(spr_idx), .row(row), .col(col),
    .scan_busy(scan_busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [13:0] sb_q[$];

  int   ref_vis [32];
  int   ref_x   [32];
  int   ref_y   [32];
  int   mdl_cnt, pend_cnt;
  logic mdl_ovf, pend_ovf;
  int   mdl_idx [4], mdl_row [4], mdl_x [4];
  int   pend_idx[4], pend_row[4], pend_x[4];

  // Reference model: wipe table and both sprite lists.
  task automatic model_clear();
    for (int e = 0; e < 32; e++) begin
      ref_vis[e] = 0; ref_x[e] = 0; ref_y[e] = 0;
    end
    mdl_cnt = 0; mdl_ovf = 1'b0; pend_cnt = 0; pend_ovf = 1'b0;
    for (int s = 0; s < 4; s++) begin
      mdl_idx[s] = 0; mdl_row[s] = 0; mdl_x[s] = 0;
      pend_idx[s] = 0; pend_row[s] = 0; pend_x[s] = 0;
    end
  endtask

  // Reference model: list of the first four visible sprites on a line.
  task automatic model_scan(input int line);
    pend_cnt = 0;
    pend_ovf = 1'b0;
    for (int e = 0; e < 32; e++) begin
      if (ref_vis[e] != 0 && line >= ref_y[e] && line - ref_y[e] < 16) begin
        if (pend_cnt < 4) begin
          pend_idx[pend_cnt] = e;
          pend_row[pend_cnt] = line - ref_y[e];
          pend_x[pend_cnt]   = ref_x[e];
          pend_cnt++;
        end else begin
          pend_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    mdl_cnt = pend_cnt;
    mdl_ovf = pend_ovf;
    for (int s = 0; s < 4; s++) begin
      mdl_idx[s] = pend_idx[s]; mdl_row[s] = pend_row[s]; mdl_x[s] = pend_x[s];
    end
  endtask

  function automatic logic [13:0] model_pix(input logic v, input int p);
    for (int s = 0; s < mdl_cnt; s++) begin
      if (v && p >= mdl_x[s] && p - mdl_x[s] < 16)
        return {1'b1, 5'(mdl_idx[s]), 4'(mdl_row[s]), 4'(p - mdl_x[s])};
    end
    return 14'd0;
  endfunction

  // One pixel cycle: score the previous pixel's result, then drive the next.
  task automatic pix_step(input logic v, input int p);
    logic [13:0] exp_v, got_v;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      got_v = {hit, spr_idx, row, col};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL pixel: got hit=%0b idx=%0d row=%0d col=%0d, expected hit=%0b idx=%0d row=%0d col=%0d",
                 got_v[13], got_v[12:8], got_v[7:4], got_v[3:0],
                 exp_v[13], exp_v[12:8], exp_v[7:4], exp_v[3:0]);
      end
    end
    pix_valid = v;
    px = 10'(p);
    sb_q.push_back(model_pix(v, p));
  endtask

  task automatic pix_drain();
    logic [13:0] exp_v, got_v;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      got_v = {hit, spr_idx, row, col};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL pixel_last: got %h, expected %h", got_v, exp_v);
      end
    end
    pix_valid = 1'b0;
  endtask

  // Sweep a column range, then one pixel with pix_valid low.
  task automatic sweep(input int lo, input int hi);
    for (int p = lo; p <= hi; p++) pix_step(1'b1, p);
    pix_step(1'b0, lo);
    pix_drain();
  endtask

  task automatic write_entry(input int sel, input int xv, input int yv, input int vis,
                             input logic pos, input logic att);
    @(negedge clk);
    sprite_sel = 5'(sel); x = 10'(xv); y = 9'(yv); visable = (vis != 0);
    load_pos = pos; load_att = att;
    if (pos) begin ref_x[sel] = xv; ref_y[sel] = yv; end
    if (att) ref_vis[sel] = vis;
    @(negedge clk);
    load_pos = 1'b0; load_att = 1'b0;
  endtask

  // Full scan; optionally clears vis on one entry in busy cycle wr_cyc.
  task automatic do_scan(input int line, input logic wr_en, input int wr_cyc, input int wr_sel);
    int n, guard;
    @(negedge clk);
    line_start = 1'b1; line_y = 9'(line);
    model_scan(line);
    @(negedge clk);
    line_start = 1'b0;
    n = 0; guard = 0;
    while (scan_busy === 1'b1 && guard < 60) begin
      n++;
      if (wr_en && n == wr_cyc) begin
        sprite_sel = 5'(wr_sel); visable = 1'b0; load_att = 1'b1;
        ref_vis[wr_sel] = 0;
      end else begin
        load_att = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    load_att = 1'b0;
    checks++;
    if (n != 33) begin
      errors++;
      $display("[TB] FAIL scan_busy_len line=%0d: got %0d cycles, expected 33", line, n);
    end
    model_commit();
    checks++;
    if (overflow !== mdl_ovf) begin
      errors++;
      $display("[TB] FAIL overflow line=%0d: got %0b, expected %0b", line, overflow, mdl_ovf);
    end
  endtask

  task automatic test_reset();
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({hit, spr_idx, row, col, scan_busy, overflow} !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", {hit, spr_idx, row, col, scan_busy, overflow});
    end
    rst = 1'b1;
    sweep(0, 639);
    checks++;
    if (scan_busy !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_status: got busy=%0b ovf=%0b, expected 0 0", scan_busy, overflow);
    end
  endtask

  task automatic test_single_sprite();
    write_entry(2, 100, 50, 1, 1'b1, 1'b1);
    do_scan(57, 1'b0, 0, 0);
    sweep(98, 117);
  endtask

  task automatic test_vertical_edges();
    int lines[4];
    lines = '{49, 50, 65, 66};
    foreach (lines[i]) begin
      do_scan(lines[i], 1'b0, 0, 0);
      sweep(98, 117);
    end
  endtask

  task automatic test_priority_overflow();
    for (int k = 0; k < 5; k++) write_entry(2 * k + 1, 200, 10, 1, 1'b1, 1'b1);
    do_scan(12, 1'b0, 0, 0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: got %0b, expected 1", overflow);
    end
    sweep(195, 220);
    write_entry(1, 0, 0, 0, 1'b0, 1'b1);
    do_scan(12, 1'b0, 0, 0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clr: got %0b, expected 0", overflow);
    end
    sweep(195, 220);
  endtask

  task automatic test_restart();
    logic [13:0] exp_v;
    int n, guard;
    do_scan(57, 1'b0, 0, 0);
    @(negedge clk);
    pix_valid = 1'b1; px = 10'd100;
    line_start = 1'b1; line_y = 9'd12;
    @(negedge clk);
    line_start = 1'b0;
    repeat (9) @(negedge clk);
    line_start = 1'b1; line_y = 9'd200;
    model_scan(200);
    @(negedge clk);
    line_start = 1'b0;
    n = 0; guard = 0;
    while (scan_busy === 1'b1 && guard < 60) begin
      n++;
      exp_v = model_pix(1'b1, 100);
      checks++;
      if ({hit, spr_idx, row, col} !== exp_v) begin
        errors++;
        $display("[TB] FAIL restart_old_list cycle=%0d: got %h, expected %h", n, {hit, spr_idx, row, col}, exp_v);
      end
      @(negedge clk);
      guard++;
    end
    checks++;
    if (n != 33) begin
      errors++;
      $display("[TB] FAIL restart_busy_len: got %0d cycles, expected 33", n);
    end
    model_commit();
    @(negedge clk);
    exp_v = model_pix(1'b1, 100);
    checks++;
    if ({hit, spr_idx, row, col} !== exp_v) begin
      errors++;
      $display("[TB] FAIL restart_new_list: got %h, expected %h", {hit, spr_idx, row, col}, exp_v);
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_write_during_scan();
    write_entry(20, 300, 100, 1, 1'b1, 1'b1);
    do_scan(105, 1'b1, 21, 20);
    sweep(296, 318);
    do_scan(105, 1'b0, 0, 0);
    sweep(296, 318);
  endtask

  task automatic test_reset_mid_scan();
    @(negedge clk);
    line_start = 1'b1; line_y = 9'd57;
    @(negedge clk);
    line_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({hit, spr_idx, row, col, scan_busy, overflow} !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_scan: got %h, expected 0", {hit, spr_idx, row, col, scan_busy, overflow});
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    do_scan(57, 1'b0, 0, 0);
    sweep(98, 117);
  endtask

  initial begin
    $display("[TB] sprite_attr_table bench start");
    test_reset();
    test_single_sprite();
    test_vertical_edges();
    test_priority_overflow();
    test_restart();
    test_write_during_scan();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
